// File: rtl/avl_arb_pkg.sv
// rtl/avl_arb_pkg.sv - shared types and constants for the two-master Avalon-MM arbiter
package avl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    MID_I = 1'b0,
    MID_D = 1'b1
  } arb_mid_t;

  // Boundary between the data region (below) and the instruction region (at and above).
  localparam logic [31:0] INSTR_BASE = 32'hBFC00000;

endpackage

// File: rtl/avl_arb_watchdog.sv
// rtl/avl_arb_watchdog.sv - saturating stall counter with sticky timeout flag
module avl_arb_watchdog
  import avl_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stall,
  output logic o_timeout_err
);

  localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_cnt;
  logic        r_err;
  logic [15:0] w_cnt_nxt;

  // Any non-stalled cycle (completion or idle) restarts the count.
  always_comb begin
    w_cnt_nxt = '0;
    if (i_stall) begin
      w_cnt_nxt = (r_cnt < LP_LIMIT) ? r_cnt + 16'd1 : r_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == LP_LIMIT) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_timeout_err = r_err;

endmodule

// File: rtl/avl_arbiter_2m.sv
// rtl/avl_arbiter_2m.sv - instruction/data master to single slave Avalon-MM arbiter
// ARB_ROUND_ROBIN_EN: IDLE ties alternate via last_grant; otherwise data master wins ties.
module avl_arbiter_2m
  import avl_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  input  logic                i_write,
  input  logic [DATA_W/8-1:0] i_byteenable,
  input  logic [DATA_W-1:0]   i_writedata,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_waitrequest,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_waitrequest,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_waitrequest,
  output logic                timeout_err
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  arb_state_t w_tie_gnt;
  logic       w_i_req;
  logic       w_d_req;
  logic       w_stall;

  assign w_i_req = i_read | i_write;
  assign w_d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  arb_mid_t r_last_grant;

  assign w_tie_gnt = (r_last_grant == MID_I) ? GNT_D : GNT_I;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= MID_I;
    end else if (w_state_nxt == GNT_I) begin
      r_last_grant <= MID_I;
    end else if (w_state_nxt == GNT_D) begin
      r_last_grant <= MID_D;
    end
  end
`else
  assign w_tie_gnt = GNT_D;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // On completion the finished master's strobes are stale, so only the other one is considered.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) begin
          w_state_nxt = w_tie_gnt;
        end else if (w_d_req) begin
          w_state_nxt = GNT_D;
        end else if (w_i_req) begin
          w_state_nxt = GNT_I;
        end
      end
      GNT_I: begin
        if (!w_i_req) begin
          w_state_nxt = IDLE;
        end else if (!m_waitrequest) begin
          w_state_nxt = w_d_req ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (!w_d_req) begin
          w_state_nxt = IDLE;
        end else if (!m_waitrequest) begin
          w_state_nxt = w_i_req ? GNT_I : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_address     = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_byteenable  = '0;
    m_writedata   = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = '0;
    d_readdata    = '0;
    case (r_state)
      GNT_I: begin
        m_address     = i_address;
        m_read        = i_read;
        m_write       = i_write;
        m_byteenable  = i_byteenable;
        m_writedata   = i_writedata;
        i_waitrequest = m_waitrequest;
        i_readdata    = i_read ? m_readdata : '0;
      end
      GNT_D: begin
        m_address     = d_address;
        m_read        = d_read;
        m_write       = d_write;
        m_byteenable  = d_byteenable;
        m_writedata   = d_writedata;
        d_waitrequest = m_waitrequest;
        d_readdata    = d_read ? m_readdata : '0;
      end
      default: ;
    endcase
  end

  assign w_stall = (r_state != IDLE) && m_waitrequest;

  avl_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_stall      (w_stall),
    .o_timeout_err(timeout_err)
  );

endmodule

// File: tb/tb_avl_arbiter_2m.sv
// tb/tb_avl_arbiter_2m.sv - directed bench with cycle-level grant model and memory scoreboard
module tb_avl_arbiter_2m;

  localparam logic [31:0] IBASE = 32'hBFC00000;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_address = '0, d_address = '0;
  logic        i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [3:0]  i_byteenable = '0, d_byteenable = '0;
  logic [31:0] i_writedata = '0, d_writedata = '0;
  logic [31:0] i_readdata, d_readdata;
  logic        i_waitrequest, d_waitrequest;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic        m_read, m_write, m_waitrequest;
  logic [3:0]  m_byteenable;
  logic        timeout_err;
  logic        slv_stall = 1'b0;

  logic [31:0] imem [16];
  logic [31:0] dmem [16];
  logic [31:0] exp_dmem [16];

  int   n_chk = 0, n_pass = 0, cyc_cnt = 0;
  int   owner = 0, last_gnt = 1, run = 0;
  logic err_m = 1'b0;
  int   glog[$];
  int   last_done_cyc = 0;
  txn_t q_i[$], q_d[$];
  txn_t cur_i, cur_d;
  logic act_i = 1'b0, act_d = 1'b0, done_i = 1'b0, done_d = 1'b0;

  avl_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_address(i_address), .i_read(i_read), .i_write(i_write), .i_byteenable(i_byteenable),
    .i_writedata(i_writedata), .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_byteenable(d_byteenable),
    .d_writedata(d_writedata), .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_byteenable(m_byteenable),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign m_waitrequest = slv_stall;
  always_comb m_readdata = (m_address >= IBASE) ? imem[m_address[5:2]] : dmem[m_address[5:2]];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return (a >= IBASE) ? imem[a[5:2]] : dmem[a[5:2]];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc_cnt);
  endtask

  // Bus-master drivers: hold each transaction until it is seen accepted, then take the next.
  always begin
    @(posedge clk);
    #2;
    if (act_i && done_i) act_i = 1'b0;
    done_i = 1'b0;
    if (!act_i && q_i.size() > 0) begin cur_i = q_i.pop_front(); act_i = 1'b1; end
    if (act_d && done_d) act_d = 1'b0;
    done_d = 1'b0;
    if (!act_d && q_d.size() > 0) begin cur_d = q_d.pop_front(); act_d = 1'b1; end
    i_read = act_i & cur_i.rd;          i_write = act_i & cur_i.wr;
    i_address = act_i ? cur_i.addr : '0; i_writedata = act_i ? cur_i.wd : '0;
    i_byteenable = act_i ? cur_i.be : '0;
    d_read = act_d & cur_d.rd;          d_write = act_d & cur_d.wr;
    d_address = act_d ? cur_d.addr : '0; d_writedata = act_d ? cur_d.wd : '0;
    d_byteenable = act_d ? cur_d.be : '0;
  end

  // Model: owner 0 = nobody, 1 = instruction master, 2 = data master.
  always @(negedge clk) begin
    logic [31:0] e_addr, e_wd, e_ird, e_drd;
    logic [3:0]  e_be;
    logic        e_rd, e_wr, e_iw, e_dw, ir, dr;
    int          nxt;
    if (!rst_n) begin owner = 0; run = 0; err_m = 1'b0; last_gnt = 1; end
    e_addr = '0; e_wd = '0; e_be = '0; e_rd = 1'b0; e_wr = 1'b0;
    e_iw = 1'b1; e_dw = 1'b1; e_ird = '0; e_drd = '0;
    if (owner == 1) begin
      e_addr = i_address; e_wd = i_writedata; e_be = i_byteenable; e_rd = i_read; e_wr = i_write;
      e_iw = slv_stall; e_ird = i_read ? rd_word(i_address) : '0;
    end else if (owner == 2) begin
      e_addr = d_address; e_wd = d_writedata; e_be = d_byteenable; e_rd = d_read; e_wr = d_write;
      e_dw = slv_stall; e_drd = d_read ? rd_word(d_address) : '0;
    end
    chk("m_address", m_address, e_addr);
    chk("m_read", 32'(m_read), 32'(e_rd));
    chk("m_write", 32'(m_write), 32'(e_wr));
    chk("m_byteenable", 32'(m_byteenable), 32'(e_be));
    chk("m_writedata", m_writedata, e_wd);
    chk("i_waitrequest", 32'(i_waitrequest), 32'(e_iw));
    chk("d_waitrequest", 32'(d_waitrequest), 32'(e_dw));
    chk("i_readdata", i_readdata, e_ird);
    chk("d_readdata", d_readdata, e_drd);
    chk("timeout_err", 32'(timeout_err), 32'(err_m));

    // Slave memory takes whatever the DUT presents; the scoreboard takes what the model expects.
    if (m_write && !m_waitrequest && m_address < IBASE)
      for (int b = 0; b < 4; b++)
        if (m_byteenable[b]) dmem[m_address[5:2]][8*b +: 8] = m_writedata[8*b +: 8];
    if (owner != 0 && e_wr && !slv_stall && e_addr < IBASE)
      for (int b = 0; b < 4; b++)
        if (e_be[b]) exp_dmem[e_addr[5:2]][8*b +: 8] = e_wd[8*b +: 8];

    if (rst_n && (i_read || i_write) && !i_waitrequest) begin
      done_i = 1'b1; glog.push_back(1); last_done_cyc = cyc_cnt;
    end
    if (rst_n && (d_read || d_write) && !d_waitrequest) begin
      done_d = 1'b1; glog.push_back(2); last_done_cyc = cyc_cnt;
    end

    ir = i_read | i_write;
    dr = d_read | d_write;
    nxt = owner;
    if (!rst_n) nxt = 0;
    else if (owner == 0) begin
      if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
        nxt = 3 - last_gnt;
`else
        nxt = 2;
`endif
      end else if (dr) nxt = 2;
      else if (ir) nxt = 1;
    end else begin
      if (!(owner == 1 ? ir : dr)) nxt = 0;
      else if (!slv_stall) nxt = (owner == 1 ? dr : ir) ? 3 - owner : 0;
    end
    run = (owner != 0 && slv_stall) ? run + 1 : 0;
    if (run >= 4) err_m = 1'b1;
    if (nxt != 0) last_gnt = nxt;
    owner = nxt;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_i(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    txn_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.wd = wd; t.be = 4'hF;
    q_i.push_back(t);
  endtask

  task automatic push_d(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    txn_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.wd = wd; t.be = 4'hF;
    q_d.push_back(t);
  endtask

  initial begin
    int first;
    int start;
    for (int k = 0; k < 16; k++) begin
      imem[k] = 32'hA0000000 + k; dmem[k] = '0; exp_dmem[k] = '0;
    end

    // Reset held with an instruction fetch pending.
    cyc(); cyc();
    push_i(1'b1, 1'b0, IBASE, '0);
    cyc(); cyc();
    chk("rst_i_wait", 32'(i_waitrequest), 32'd1);
    chk("rst_d_wait", 32'(d_waitrequest), 32'd1);
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_i_read_held", 32'(i_read), 32'd1);
    rst_n = 1'b1;
    cyc();
    chk("first_m_read", 32'(m_read), 32'd1);
    chk("first_m_addr", m_address, 32'hBFC00000);
    chk("first_i_wait", 32'(i_waitrequest), 32'd0);
    chk("first_i_rdata", i_readdata, 32'hA0000000);
    repeat (3) cyc();

    // IDLE tie right after reset: data master first either way.
    glog.delete();
    push_i(1'b1, 1'b0, IBASE + 32'h4, '0);
    push_d(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    repeat (5) cyc();
    chk("tie1_count", 32'(glog.size()), 32'd2);
    chk("tie1_first", 32'(glog[0]), 32'd2);
    chk("tie1_second", 32'(glog[1]), 32'd1);
    chk("tie1_dmem4", dmem[4], 32'hDEADBEEF);

    // A lone data access leaves last_grant at D before the second tie.
    push_d(1'b1, 1'b0, 32'h10, '0);
    repeat (4) cyc();
    glog.delete();
    push_i(1'b1, 1'b0, IBASE + 32'h8, '0);
    push_d(1'b1, 1'b0, 32'h14, '0);
    repeat (5) cyc();
`ifdef ARB_ROUND_ROBIN_EN
    first = 1;
`else
    first = 2;
`endif
    chk("tie2_count", 32'(glog.size()), 32'd2);
    chk("tie2_first", 32'(glog[0]), 32'(first));

    // Continuous requests from both masters alternate grants at one per cycle.
    glog.delete();
    push_i(1'b1, 1'b0, IBASE + 32'h10, '0);
    push_i(1'b1, 1'b0, IBASE + 32'h14, '0);
    push_d(1'b1, 1'b0, 32'h10, '0);
    push_d(1'b1, 1'b0, 32'h14, '0);
    start = cyc_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    first = 1;
`else
    first = 2;
`endif
    repeat (7) cyc();
    chk("ho_count", 32'(glog.size()), 32'd4);
    chk("ho_g0", 32'(glog[0]), 32'(first));
    chk("ho_g1", 32'(glog[1]), 32'(3 - first));
    chk("ho_g2", 32'(glog[2]), 32'(first));
    chk("ho_g3", 32'(glog[3]), 32'(3 - first));
    chk("ho_cycles", 32'(last_done_cyc - start + 1), 32'd5);

    // Three stalled cycles on a data write, completing on the fourth.
    push_d(1'b0, 1'b1, 32'h14, 32'h12345678);
    slv_stall = 1'b1;
    cyc();
    for (int j = 0; j < 3; j++) begin
      chk("stall_d_wait", 32'(d_waitrequest), 32'd1);
      chk("stall_i_wait", 32'(i_waitrequest), 32'd1);
      if (j < 2) cyc();
    end
    cyc();
    slv_stall = 1'b0;
    #1;
    chk("stall_done_d_wait", 32'(d_waitrequest), 32'd0);
    cyc();
    chk("stall_idle_m_write", 32'(m_write), 32'd0);
    chk("stall_idle_d_wait", 32'(d_waitrequest), 32'd1);
    chk("stall_no_err", 32'(timeout_err), 32'd0);

    // Watchdog: flag rises after the fourth stalled cycle and stays.
    push_i(1'b1, 1'b0, IBASE + 32'hC, '0);
    slv_stall = 1'b1;
    repeat (4) cyc();
    chk("wd_before", 32'(timeout_err), 32'd0);
    cyc();
    chk("wd_rise", 32'(timeout_err), 32'd1);
    slv_stall = 1'b0;
    repeat (3) cyc();
    chk("wd_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of a stalled data write.
    push_d(1'b0, 1'b1, 32'h18, 32'hCAFEF00D);
    slv_stall = 1'b1;
    cyc(); cyc();
    chk("mr_pre_m_write", 32'(m_write), 32'd1);
    rst_n = 1'b0;
    act_d = 1'b0;
    #2;
    chk("mr_m_write", 32'(m_write), 32'd0);
    chk("mr_d_wait", 32'(d_waitrequest), 32'd1);
    chk("mr_err_clear", 32'(timeout_err), 32'd0);
    cyc();
    slv_stall = 1'b0;
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("mr_idle_m_write", 32'(m_write), 32'd0);
    chk("mr_dmem6", dmem[6], 32'h0);
    chk("final_dmem5", dmem[5], 32'h12345678);

    for (int k = 0; k < 16; k++) chk($sformatf("dmem[%0d]", k), dmem[k], exp_dmem[k]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
